// File: rtl/operand_stack.sv
// ---------------------------------------------------------------------------
// operand_stack
//   Hardware operand stack feeding the ALU of the stack-machine datapath.
//   The top two entries are presented combinationally as ALU operands
//   (opnd_a = NOS, opnd_b = TOS), so an arithmetic command can write the
//   ALU result back in the same cycle it is issued.
//
// Ports
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd : one command per cycle (NOP/PUSH/POP/BIN/UNI/DUP)
//   push_data     : operand for PUSH
//   alu_result    : ALU output, written back on BIN/UNI
//   opnd_a/opnd_b : NOS/TOS to the ALU, zero when that entry does not exist
//   pop_data      : value removed by the last successful POP (held)
//   pop_valid     : one-cycle pulse after each successful POP
//   count/empty/full : occupancy status
//   err/err_code  : sticky error flag and first error code since last clear
//   err_clr       : clears err/err_code unless a new error occurs that cycle
// ---------------------------------------------------------------------------
module operand_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   input  logic [2:0]               cmd,
   input  logic [WIDTH-1:0]         push_data,
   input  logic [WIDTH-1:0]         alu_result,
   output logic [WIDTH-1:0]         opnd_a,
   output logic [WIDTH-1:0]         opnd_b,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     pop_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     err,
   output logic [1:0]               err_code,
   input  logic                     err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] C_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] C_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] C_TWO   = C_ONE + C_ONE;
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   localparam logic [2:0] CMD_NOP  = 3'b000;
   localparam logic [2:0] CMD_PUSH = 3'b001;
   localparam logic [2:0] CMD_POP  = 3'b010;
   localparam logic [2:0] CMD_BIN  = 3'b011;
   localparam logic [2:0] CMD_UNI  = 3'b100;
   localparam logic [2:0] CMD_DUP  = 3'b101;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_OVER  = 2'b01;
   localparam logic [1:0] ERR_UNDER = 2'b10;
   localparam logic [1:0] ERR_RSVD  = 2'b11;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_pop_data;
   logic             r_pop_valid;
   logic             r_err;
   logic [1:0]       r_err_code;

   logic [CW-1:0]    w_tos_full;
   logic [CW-1:0]    w_nos_full;
   logic [AW-1:0]    w_sp_idx;
   logic [AW-1:0]    w_tos_idx;
   logic [AW-1:0]    w_nos_idx;
   logic [WIDTH-1:0] w_tos;
   logic [WIDTH-1:0] w_nos;
   logic             w_empty;
   logic             w_full;
   logic             w_ge2;

   logic             w_wr_en;
   logic [AW-1:0]    w_wr_idx;
   logic [WIDTH-1:0] w_wr_data;
   logic [CW-1:0]    w_count_nxt;
   logic             w_pop_ok;
   logic             w_err_new;
   logic [1:0]       w_err_code_new;

   // Pointer arithmetic: sp equals count; the index wraps only in cases
   // where the corresponding command is rejected, so no slot is corrupted.
   assign w_tos_full = r_count - C_ONE;
   assign w_nos_full = r_count - C_TWO;
   assign w_sp_idx   = r_count[AW-1:0];
   assign w_tos_idx  = w_tos_full[AW-1:0];
   assign w_nos_idx  = w_nos_full[AW-1:0];
   assign w_tos      = r_mem[w_tos_idx];
   assign w_nos      = r_mem[w_nos_idx];

   assign w_empty = (r_count == C_ZERO);
   assign w_full  = (r_count == C_DEPTH);
   assign w_ge2   = (r_count >= C_TWO);

   // Operands are gated by occupancy so stale memory never reaches the ALU.
   assign opnd_a    = w_ge2   ? w_nos : {WIDTH{1'b0}};
   assign opnd_b    = w_empty ? {WIDTH{1'b0}} : w_tos;
   assign count     = r_count;
   assign empty     = w_empty;
   assign full      = w_full;
   assign pop_data  = r_pop_data;
   assign pop_valid = r_pop_valid;
   assign err       = r_err;
   assign err_code  = r_err_code;

   // Command decode: legality check, memory write request and next count.
   always_comb begin
      w_wr_en        = 1'b0;
      w_wr_idx       = w_sp_idx;
      w_wr_data      = push_data;
      w_count_nxt    = r_count;
      w_pop_ok       = 1'b0;
      w_err_new      = 1'b0;
      w_err_code_new = ERR_NONE;
      if (cmd_valid) begin
         case (cmd)
            CMD_NOP: begin
               w_count_nxt = r_count;
            end
            CMD_PUSH: begin
               if (w_full) begin
                  w_err_new      = 1'b1;
                  w_err_code_new = ERR_OVER;
               end else begin
                  w_wr_en     = 1'b1;
                  w_wr_idx    = w_sp_idx;
                  w_wr_data   = push_data;
                  w_count_nxt = r_count + C_ONE;
               end
            end
            CMD_POP: begin
               if (w_empty) begin
                  w_err_new      = 1'b1;
                  w_err_code_new = ERR_UNDER;
               end else begin
                  w_pop_ok    = 1'b1;
                  w_count_nxt = r_count - C_ONE;
               end
            end
            CMD_BIN: begin
               // Result of NOS op TOS replaces NOS; TOS is discarded.
               if (!w_ge2) begin
                  w_err_new      = 1'b1;
                  w_err_code_new = ERR_UNDER;
               end else begin
                  w_wr_en     = 1'b1;
                  w_wr_idx    = w_nos_idx;
                  w_wr_data   = alu_result;
                  w_count_nxt = r_count - C_ONE;
               end
            end
            CMD_UNI: begin
               if (w_empty) begin
                  w_err_new      = 1'b1;
                  w_err_code_new = ERR_UNDER;
               end else begin
                  w_wr_en   = 1'b1;
                  w_wr_idx  = w_tos_idx;
                  w_wr_data = alu_result;
               end
            end
            CMD_DUP: begin
               if (w_full) begin
                  w_err_new      = 1'b1;
                  w_err_code_new = ERR_OVER;
               end else begin
                  w_wr_en     = 1'b1;
                  w_wr_idx    = w_sp_idx;
                  w_wr_data   = w_tos;
                  w_count_nxt = r_count + C_ONE;
               end
            end
            default: begin
               w_err_new      = 1'b1;
               w_err_code_new = ERR_RSVD;
            end
         endcase
      end else begin
         w_count_nxt = r_count;
      end
   end

   // Stack storage; contents are don't-care after reset because every read
   // is gated by count.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_idx] <= w_wr_data;
      end
   end

   // Occupancy, pop result and pop strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count     <= C_ZERO;
         r_pop_data  <= {WIDTH{1'b0}};
         r_pop_valid <= 1'b0;
      end else begin
         r_count     <= w_count_nxt;
         r_pop_valid <= w_pop_ok;
         if (w_pop_ok) begin
            r_pop_data <= w_tos;
         end
      end
   end

   // Sticky error: the first code wins unless err_clr coincides with a new
   // error, in which case the new code replaces the cleared one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
      end else if (w_err_new) begin
         r_err <= 1'b1;
         if (!r_err || err_clr) begin
            r_err_code <= w_err_code_new;
         end
      end else if (err_clr) begin
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
      end
   end

endmodule

// File: tb/tb_operand_stack.sv
// ---------------------------------------------------------------------------
// tb_operand_stack
//   Self-checking bench for operand_stack. A reference stack model tracks
//   expected occupancy, operands and error state after every command; values
//   removed by POP are queued and compared when pop_valid is observed.
// ---------------------------------------------------------------------------
module tb_operand_stack;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   localparam logic [2:0] NOP  = 3'b000;
   localparam logic [2:0] PUSH = 3'b001;
   localparam logic [2:0] POP  = 3'b010;
   localparam logic [2:0] BIN  = 3'b011;
   localparam logic [2:0] UNI  = 3'b100;
   localparam logic [2:0] DUP  = 3'b101;
   localparam logic [2:0] RSV6 = 3'b110;
   localparam logic [2:0] RSV7 = 3'b111;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic [2:0]       cmd;
   logic [WIDTH-1:0] push_data;
   logic [WIDTH-1:0] alu_result;
   logic [WIDTH-1:0] opnd_a;
   logic [WIDTH-1:0] opnd_b;
   logic [WIDTH-1:0] pop_data;
   logic             pop_valid;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             err;
   logic [1:0]       err_code;
   logic             err_clr;

   int n_checks = 0;
   int n_errors = 0;

   logic [WIDTH-1:0] m_stk[$];
   logic [WIDTH-1:0] exp_pop_q[$];
   logic             m_err;
   logic [1:0]       m_code;

   operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd        (cmd),
      .push_data  (push_data),
      .alu_result (alu_result),
      .opnd_a     (opnd_a),
      .opnd_b     (opnd_b),
      .pop_data   (pop_data),
      .pop_valid  (pop_valid),
      .count      (count),
      .empty      (empty),
      .full       (full),
      .err        (err),
      .err_code   (err_code),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model();
      int n;
      logic [WIDTH-1:0] ea, eb;
      n  = m_stk.size();
      ea = (n >= 2) ? m_stk[n-2] : 8'h00;
      eb = (n >= 1) ? m_stk[n-1] : 8'h00;
      check_value("count", 32'(count), 32'(n));
      check_value("empty", 32'(empty), 32'(n == 0));
      check_value("full", 32'(full), 32'(n == DEPTH));
      check_value("opnd_a", 32'(opnd_a), 32'(ea));
      check_value("opnd_b", 32'(opnd_b), 32'(eb));
      check_value("err", 32'(err), 32'(m_err));
      check_value("err_code", 32'(err_code), 32'(m_code));
   endtask

   // Issue one command at posedge+1, update the model, sample at next posedge+1.
   task automatic run_cmd(input logic [2:0] c, input logic [WIDTH-1:0] d,
                          input logic [WIDTH-1:0] alu, input logic clr);
      int n;
      logic ill;
      logic [1:0] code;
      logic [WIDTH-1:0] t;
      n = m_stk.size();
      ill = 1'b0;
      code = 2'b00;
      case (c)
         PUSH: if (n == DEPTH) begin ill = 1'b1; code = 2'b01; end
               else m_stk.push_back(d);
         POP:  if (n == 0) begin ill = 1'b1; code = 2'b10; end
               else begin t = m_stk.pop_back(); exp_pop_q.push_back(t); end
         BIN:  if (n < 2) begin ill = 1'b1; code = 2'b10; end
               else begin
                  void'(m_stk.pop_back());
                  void'(m_stk.pop_back());
                  m_stk.push_back(alu);
               end
         UNI:  if (n == 0) begin ill = 1'b1; code = 2'b10; end
               else begin void'(m_stk.pop_back()); m_stk.push_back(alu); end
         DUP:  if (n == DEPTH) begin ill = 1'b1; code = 2'b01; end
               else m_stk.push_back(m_stk[n-1]);
         RSV6, RSV7: begin ill = 1'b1; code = 2'b11; end
         default: ;
      endcase
      if (ill) begin
         if (!m_err || clr) m_code = code;
         m_err = 1'b1;
      end else if (clr) begin
         m_err  = 1'b0;
         m_code = 2'b00;
      end
      cmd_valid  = 1'b1;
      cmd        = c;
      push_data  = d;
      alu_result = alu;
      err_clr    = clr;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd       = NOP;
      err_clr   = 1'b0;
      check_model();
   endtask

   // Scoreboard consumer: every pop_valid pulse must match a queued value.
   always @(negedge clk) begin
      if (!rst && pop_valid) begin
         if (exp_pop_q.size() == 0)
            check_value("pop_unexpected", 32'(1), 32'(0));
         else
            check_value("pop_data", 32'(pop_data), 32'(exp_pop_q.pop_front()));
      end
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd = NOP; push_data = 8'h00;
      alu_result = 8'h00; err_clr = 1'b0;
      m_err = 1'b0; m_code = 2'b00;
      #12;
      check_model();
      check_value("rst_pop_data", 32'(pop_data), 32'(0));
      check_value("rst_pop_valid", 32'(pop_valid), 32'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Push/push/sub, then boundary BIN at count=2.
      run_cmd(PUSH, 8'h05, 8'h00, 1'b0);
      run_cmd(PUSH, 8'h03, 8'h00, 1'b0);
      run_cmd(BIN, 8'h00, 8'h02, 1'b0);

      // Unary op then pop to empty.
      run_cmd(POP, 8'h00, 8'h00, 1'b0);
      run_cmd(PUSH, 8'h0F, 8'h00, 1'b0);
      run_cmd(UNI, 8'h00, 8'hF0, 1'b0);
      run_cmd(POP, 8'h00, 8'h00, 1'b0);
      check_value("pop_data_hold", 32'(pop_data), 32'(8'hF0));

      // Fill, overflow, drain.
      for (int i = 1; i <= DEPTH; i++) run_cmd(PUSH, 8'(i), 8'h00, 1'b0);
      run_cmd(PUSH, 8'hAA, 8'h00, 1'b0);
      check_value("ovf_tos", 32'(opnd_b), 32'(8'h08));
      for (int i = 0; i < DEPTH; i++) run_cmd(POP, 8'h00, 8'h00, 1'b0);
      check_value("drain_last", 32'(pop_data), 32'(8'h01));
      run_cmd(NOP, 8'h00, 8'h00, 1'b1);

      // Underflow, first-error-wins, clear, clear with new error.
      run_cmd(POP, 8'h00, 8'h00, 1'b0);
      run_cmd(PUSH, 8'h09, 8'h00, 1'b0);
      run_cmd(BIN, 8'h00, 8'h55, 1'b0);
      run_cmd(NOP, 8'h00, 8'h00, 1'b1);
      run_cmd(RSV7, 8'h00, 8'h00, 1'b1);
      run_cmd(RSV6, 8'h00, 8'h00, 1'b0);
      run_cmd(UNI, 8'h00, 8'h66, 1'b1);
      run_cmd(POP, 8'h00, 8'h00, 1'b0);
      run_cmd(UNI, 8'h00, 8'h77, 1'b0);
      run_cmd(NOP, 8'h00, 8'h00, 1'b1);

      // DUP, then ignored commands with cmd_valid low.
      run_cmd(PUSH, 8'h7E, 8'h00, 1'b0);
      run_cmd(DUP, 8'h00, 8'h00, 1'b0);
      cmd = POP;
      repeat (3) begin
         @(posedge clk); #1;
         check_model();
      end
      cmd = NOP;
      run_cmd(BIN, 8'h00, 8'hFC, 1'b0);
      run_cmd(POP, 8'h00, 8'h00, 1'b0);

      // Asynchronous reset mid-cycle with error and pop pulse pending.
      run_cmd(PUSH, 8'h11, 8'h00, 1'b0);
      run_cmd(PUSH, 8'h22, 8'h00, 1'b0);
      run_cmd(PUSH, 8'h33, 8'h00, 1'b0);
      run_cmd(RSV6, 8'h00, 8'h00, 1'b0);
      run_cmd(POP, 8'h00, 8'h00, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      m_stk.delete();
      exp_pop_q.delete();
      m_err = 1'b0;
      m_code = 2'b00;
      check_model();
      check_value("arst_pop_valid", 32'(pop_valid), 32'(0));
      check_value("arst_pop_data", 32'(pop_data), 32'(0));
      #3;
      rst = 1'b0;
      @(posedge clk); #1;
      run_cmd(PUSH, 8'h44, 8'h00, 1'b0);
      run_cmd(POP, 8'h00, 8'h00, 1'b0);
      @(posedge clk); #1;
      check_value("pop_q_drained", 32'(exp_pop_q.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
